instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch_if.sv | 35 +++
 rtl/instruction_fetch.sv | 134 +++++++++++++
 tb/tb_instruction_fetch.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// +--------------------------------------------------------------------------+
// | instruction_fetch_if : PC/strobe, memory and IR signals of the fetch stage|
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface instruction_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] pc;
  logic              fetch_strobe;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic              busy;
  logic              overrun;
  logic              fault;

  // master: control unit + memory side; slave: the fetch stage itself
  modport master (
    output pc, fetch_strobe, mem_ack, mem_rdata,
    input  mem_addr, mem_req, ir, ir_valid, busy, overrun, fault
  );

  modport slave (
    input  pc, fetch_strobe, mem_ack, mem_rdata,
    output mem_addr, mem_req, ir, ir_valid, busy, overrun, fault
  );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch.sv
// +--------------------------------------------------------------------------+
// | instruction_fetch : captures PC on strobe, req/ack memory read, loads IR |
// | Optional memory timeout: FETCH_TIMEOUT_EN. Revision 1.0                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module instruction_fetch #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  wire logic           clock,
  input  wire logic           reset,
  instruction_fetch_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              overrun_q, overrun_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int             CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] wait_q, wait_d;
  logic             fault_q, fault_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    overrun_d  = overrun_q;
`ifdef FETCH_TIMEOUT_EN
    wait_d     = wait_q;
    fault_d    = fault_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.fetch_strobe) begin
          mem_addr_d = bus.pc;
          mem_req_d  = 1'b1;
          ir_valid_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
          wait_d     = '0;
`endif
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.fetch_strobe) begin
          overrun_d = 1'b1;
        end
        // An ack always wins over a timeout expiring in the same cycle
        if (bus.mem_ack) begin
          ir_d       = bus.mem_rdata;
          ir_valid_d = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = ST_IDLE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wait_q == TIMEOUT_CNT) begin
          mem_req_d = 1'b0;
          fault_d   = 1'b1;
          state_d   = ST_FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_q     <= '0;
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      overrun_q  <= overrun_d;
`ifdef FETCH_TIMEOUT_EN
      wait_q     <= wait_d;
      fault_q    <= fault_d;
`endif
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.busy     = (state_q == ST_REQ);
  assign bus.overrun  = overrun_q;
`ifdef FETCH_TIMEOUT_EN
  assign bus.fault    = fault_q;
`else
  assign bus.fault    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// +--------------------------------------------------------------------------+
// | tb_instruction_fetch : scoreboard bench for instruction_fetch            |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_instruction_fetch;

  logic clk;
  logic rst;

  instruction_fetch_if #(.ADDR_W(16), .DATA_W(16)) bus_if ();

  instruction_fetch #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec;
  int          n_err;
  logic [15:0] exp_ir;
  logic        exp_overrun;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.fetch_strobe = 1'b0;
    bus_if.mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    exp_ir = 16'h0000;
    exp_overrun = 1'b0;
  endtask

  // Idle cycles with optional stray acks that must be ignored
  task automatic idle(input int n, input bit stray_ack);
    for (int i = 0; i < n; i++) begin
      bus_if.mem_ack = stray_ack;
      bus_if.mem_rdata = 16'hDEAD;
      @(negedge clk);
      bus_if.mem_ack = 1'b0;
      check("idle_req", {31'd0, bus_if.mem_req}, 32'd0);
      check("idle_ir", {16'd0, bus_if.ir}, {16'd0, exp_ir});
    end
  endtask

  // Called just after a negedge; returns just after the completion negedge.
  // ovr_mode: 0 none, 1 strobe during a wait cycle, 2 strobe in the ack cycle
  task automatic fetch(input logic [15:0] addr, input logic [15:0] data,
                       input int waits, input int ovr_mode);
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    bus_if.pc = addr;
    bus_if.fetch_strobe = 1'b1;
    sb_q.push_back({addr, data});
    @(negedge clk);
    bus_if.fetch_strobe = 1'b0;
    check("start_ir_valid", {31'd0, bus_if.ir_valid}, 32'd0);
    check("hold_ir", {16'd0, bus_if.ir}, {16'd0, exp_ir});
    for (int i = 0; i < waits; i++) begin
      check("wait_req", {31'd0, bus_if.mem_req}, 32'd1);
      check("wait_addr", {16'd0, bus_if.mem_addr}, {16'd0, sb_q[0].addr});
      busy_cnt += int'(bus_if.busy);
      bus_if.pc = 16'h0010;
      bus_if.mem_ack = 1'b0;
      bus_if.fetch_strobe = (ovr_mode == 1 && i == 0);
      @(negedge clk);
      bus_if.fetch_strobe = 1'b0;
    end
    check("ack_req", {31'd0, bus_if.mem_req}, 32'd1);
    check("ack_addr", {16'd0, bus_if.mem_addr}, {16'd0, sb_q[0].addr});
    busy_cnt += int'(bus_if.busy);
    bus_if.mem_ack = 1'b1;
    bus_if.mem_rdata = data;
    bus_if.fetch_strobe = (ovr_mode == 2);
    @(negedge clk);
    bus_if.mem_ack = 1'b0;
    bus_if.fetch_strobe = 1'b0;
    bus_if.mem_rdata = 16'($urandom);
    if (ovr_mode != 0) exp_overrun = 1'b1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      exp_ir = e.data;
      check("done_ir", {16'd0, bus_if.ir}, {16'd0, e.data});
    end
    check("done_ir_valid", {31'd0, bus_if.ir_valid}, 32'd1);
    check("done_req", {31'd0, bus_if.mem_req}, 32'd0);
    check("done_busy", {31'd0, bus_if.busy}, 32'd0);
    check("busy_cycles", busy_cnt, waits + 1);
    check("overrun", {31'd0, bus_if.overrun}, {31'd0, exp_overrun});
    check("fault", {31'd0, bus_if.fault}, 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus_if.pc = 16'h0000;
    bus_if.fetch_strobe = 1'b0;
    bus_if.mem_ack = 1'b0;
    bus_if.mem_rdata = 16'h0000;
    do_reset();

    check("rst_req", {31'd0, bus_if.mem_req}, 32'd0);
    check("rst_addr", {16'd0, bus_if.mem_addr}, 32'd0);
    check("rst_ir", {16'd0, bus_if.ir}, 32'd0);
    check("rst_ir_valid", {31'd0, bus_if.ir_valid}, 32'd0);
    check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    check("rst_overrun", {31'd0, bus_if.overrun}, 32'd0);
    check("rst_fault", {31'd0, bus_if.fault}, 32'd0);

    // Reset during REQ with an ack in the reset cycle
    bus_if.pc = 16'h0040;
    bus_if.fetch_strobe = 1'b1;
    @(negedge clk);
    bus_if.fetch_strobe = 1'b0;
    check("mid_req", {31'd0, bus_if.mem_req}, 32'd1);
    check("mid_addr", {16'd0, bus_if.mem_addr}, 32'h0040);
    rst = 1'b1;
    bus_if.mem_ack = 1'b1;
    bus_if.mem_rdata = 16'hFFFF;
    @(negedge clk);
    rst = 1'b0;
    bus_if.mem_ack = 1'b0;
    check("mrst_req", {31'd0, bus_if.mem_req}, 32'd0);
    check("mrst_addr", {16'd0, bus_if.mem_addr}, 32'd0);
    check("mrst_ir", {16'd0, bus_if.ir}, 32'd0);
    check("mrst_ir_valid", {31'd0, bus_if.ir_valid}, 32'd0);
    check("mrst_busy", {31'd0, bus_if.busy}, 32'd0);
    idle(2, 1'b1);

    fetch(16'h0004, 16'hA5C3, 0, 0);
    fetch(16'h0020, 16'h1234, 3, 0);
    fetch(16'h0022, 16'h5A5A, 0, 0);
    idle(3, 1'b1);
    fetch(16'h0030, 16'hBEEF, 2, 1);
    idle(2, 1'b0);
    fetch(16'h0032, 16'hC0DE, 1, 2);
    idle(2, 1'b0);
    check("ovr_sticky", {31'd0, bus_if.overrun}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      fetch(16'($urandom), 16'($urandom), int'($urandom_range(0, 4)), 0);
    end

`ifdef FETCH_TIMEOUT_EN
    do_reset();
    bus_if.pc = 16'h0100;
    bus_if.fetch_strobe = 1'b1;
    @(negedge clk);
    bus_if.fetch_strobe = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("to_req", {31'd0, bus_if.mem_req}, 32'd1);
      @(negedge clk);
    end
    check("to_req_drop", {31'd0, bus_if.mem_req}, 32'd0);
    check("to_fault", {31'd0, bus_if.fault}, 32'd1);
    check("to_busy", {31'd0, bus_if.busy}, 32'd0);
    bus_if.pc = 16'h0200;
    bus_if.fetch_strobe = 1'b1;
    @(negedge clk);
    bus_if.fetch_strobe = 1'b0;
    @(negedge clk);
    check("flt_req", {31'd0, bus_if.mem_req}, 32'd0);
    check("flt_overrun", {31'd0, bus_if.overrun}, 32'd0);
    check("flt_ir_valid", {31'd0, bus_if.ir_valid}, 32'd0);
    check("flt_ir", {16'd0, bus_if.ir}, 32'd0);
    check("flt_sticky", {31'd0, bus_if.fault}, 32'd1);
    do_reset();
    fetch(16'h0300, 16'h7E57, 15, 0);
`else
    fetch(16'h0400, 16'h600D, 100, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
